if_controller: RTL
==================

IF_CONTROLLER -- requirements
Module: if_controller

Interface
REQ-001 Parameter DIM, default 8: systolic array dimension; drain length = 2*DIM-1 cycles.
REQ-002 Parameter AW, default 16: width of activation address and length.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low (0 = reset).
REQ-005 start_if  input  1  one-cycle pulse from weight controller; begins an activation stream.
REQ-006 if_len  input  AW  number of activation vectors; sampled only when start_if=1 in IDLE.
REQ-007 acc_ready  input  1  downstream accumulator accepts data this cycle; 0 = stall.
REQ-008 if_ready  output  1  controller idle, able to accept start_if.
REQ-009 if_read  output  1  read strobe to activation buffer at if_addr.
REQ-010 if_addr  output  AW  activation buffer read address.
REQ-011 array_en  output  1  advance systolic array one step.
REQ-012 if_done  output  1  one-cycle pulse, stream and drain complete.

Function
REQ-013 States: IDLE, STREAM, DRAIN, DONE; state register only, next-state logic combinational.
REQ-014 IDLE: if_ready=1, if_read=0, array_en=0; start_if with if_len!=0 latches len, clears if_addr, next state STREAM.
REQ-015 IDLE with start_if and if_len==0: no STREAM/DRAIN; next state DONE.
REQ-016 start_if outside IDLE is ignored; latched len and address unchanged.
REQ-017 STREAM: if_read = array_en = acc_ready, combinational, same cycle.
REQ-018 STREAM: each cycle with acc_ready=1, if_addr increments by 1 at the next edge; acc_ready=0 holds if_addr and state.
REQ-019 STREAM: read when if_addr == len-1 is the last; next state DRAIN, drain counter cleared.
REQ-020 DRAIN: if_read=0, array_en=acc_ready; drain counter increments only when acc_ready=1.
REQ-021 DRAIN: exits to DONE after 2*DIM-1 enabled cycles; stalls never shorten it.
REQ-022 DONE: if_done=1 for exactly one cycle, all other strobes 0; next state IDLE unconditionally.
REQ-023 if_ready=1 only in IDLE; 0 in STREAM, DRAIN and DONE.
REQ-024 Maximum len = 2^AW-1; if_addr never wraps within a stream.
REQ-025 Latency: start_if at cycle t -> first if_read at t+1, if acc_ready=1.
REQ-026 Unenabled cycles = total stall cycles; stream with no stalls takes len + 2*DIM-1 + 1 cycles from STREAM entry to if_done.

Reset
REQ-027 rst=0 at a clock edge: state IDLE, if_addr=0, latched len=0, drain counter=0.
REQ-028 During and after reset: if_ready=1, if_read=0, array_en=0, if_done=0.
REQ-029 Reset mid-STREAM or mid-DRAIN aborts the stream; no if_done pulse.

Structure
REQ-030 Shared package accel_pkg holds the state enum if_state_t, DIM default, and AW default.
REQ-031 Drain count 2*DIM-1 is a localparam derived from DIM; counter width $clog2(2*DIM).
REQ-032 One sub-module is natural: up_counter (enable, clear, count), instantiated for if_addr and the drain counter.

Verification
REQ-033 Reset, then start_if with if_len=4, acc_ready=1 -> if_addr 0,1,2,3 on successive if_read; 15 array_en in DRAIN; if_done 20 cycles after start.
REQ-034 if_len=3, acc_ready=0 for 2 cycles mid-STREAM -> if_addr held, if_read=0 during stall; if_done delayed by exactly 2 cycles.
REQ-035 start_if with if_len=0 -> if_read never asserted; if_done on the second cycle; if_ready back to 1 on the third.
REQ-036 Second start_if during STREAM with if_len=9 -> ignored; original len=4 completes, single if_done.
REQ-037 rst=0 in DRAIN after 5 drain cycles -> next cycle IDLE, if_ready=1, if_addr=0, no if_done.
REQ-038 Back-to-back: start_if on the cycle after if_done -> accepted; new stream starts at if_addr=0.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and default sizing for the accelerator control blocks.
// Holds the activation-feed state encoding and the array/address defaults.
package accel_pkg;

    localparam int DIM_DEFAULT = 8;
    localparam int AW_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } if_state_t;

endpackage

// File: rtl/up_counter.sv
// Generic up counter with synchronous active-low reset, clear and enable.
// Clear has priority over enable.
module up_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_controller.sv
// Activation feed controller: streams if_len buffer reads into the systolic
// array, then clocks the array 2*DIM-1 more enabled steps to drain it.
module if_controller
    import accel_pkg::*;
#(
    parameter int DIM = DIM_DEFAULT,
    parameter int AW  = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_if,
    input  logic [AW-1:0] if_len,
    input  logic          acc_ready,
    output logic          if_ready,
    output logic          if_read,
    output logic [AW-1:0] if_addr,
    output logic          array_en,
    output logic          if_done
);

    localparam int DRAIN_LEN = 2 * DIM - 1;
    localparam int DW        = $clog2(2 * DIM);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

    if_state_t     state;
    if_state_t     next_state;
    logic [AW-1:0] len;
    logic [DW-1:0] drain_cnt;

    logic accept;
    logic last_read;
    logic drain_end;
    logic addr_en;
    logic drain_en;

    always_comb begin
        accept    = (state == IDLE) && start_if;
        addr_en   = (state == STREAM) && acc_ready;
        drain_en  = (state == DRAIN) && acc_ready;
        last_read = addr_en && (if_addr == len - 1'b1);
        drain_end = drain_en && (drain_cnt == DRAIN_LAST);
    end

    up_counter #(
        .W (AW)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (addr_en),
        .count (if_addr)
    );

    // Cleared on the final read so DRAIN always starts counting from zero.
    up_counter #(
        .W (DW)
    ) u_drain_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (last_read),
        .en    (drain_en),
        .count (drain_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            len <= '0;
        end else if (accept) begin
            len <= if_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if_ready   = 1'b0;
        if_read    = 1'b0;
        array_en   = 1'b0;
        if_done    = 1'b0;

        case (state)
            IDLE: begin
                if_ready = 1'b1;
                if (start_if) begin
                    next_state = (if_len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if_read  = acc_ready;
                array_en = acc_ready;
                if (last_read) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                array_en = acc_ready;
                if (drain_end) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if_done    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
